// File: rtl/signed_mult_pipe.sv
// Pipelined signed two's-complement multiplier: sign-magnitude operands, unsigned multiply core, negate on output.
// Optional registered Q-format rounded/saturated output P_Q when SIGNED_MULT_QOUT_EN is defined.
module signed_mult_pipe #(
  parameter int WIDTH       = 16,
  parameter int MULT_STAGES = 2,
  parameter int FRAC        = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   P,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef SIGNED_MULT_QOUT_EN
  ,
  output logic [WIDTH-1:0]     P_Q
`endif
);

  localparam int PW = 2 * WIDTH;

  if (WIDTH < 4 || WIDTH > 32 || MULT_STAGES < 1 || MULT_STAGES > 4 ||
      FRAC < 1 || FRAC > WIDTH - 1) begin : g_bad_params
    $error("signed_mult_pipe: parameter out of range");
  end

  // Handshake: input transfers on in_valid & in_ready, output on out_valid & out_ready.
  // The whole pipeline advances as one when the output register is empty or being drained,
  // so in_ready is that same advance term and every stage (valid bits too) holds otherwise.
  logic advance;

  // Stage 0: operand magnitudes and product sign
  logic [WIDTH-1:0] mag_a_d, mag_b_d;
  logic             sgn0_d;
  logic [WIDTH-1:0] mag_a_q, mag_b_q;
  logic             sgn0_q;
  logic             vld0_q;

  // Multiply stages
  logic [PW-1:0]    mul_d;
  logic [PW-1:0]    prod_q [MULT_STAGES];
  logic             sgn_q  [MULT_STAGES];
  logic             vld_q  [MULT_STAGES];

  // Output stage
  logic [PW-1:0]    p_d;
  logic [PW-1:0]    p_q;
  logic             out_valid_q;

  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance;

  // Negating the most-negative value yields 2^(WIDTH-1), which is exact as an unsigned magnitude.
  always_comb begin
    mag_a_d = A[WIDTH-1] ? -A : A;
    mag_b_d = B[WIDTH-1] ? -B : B;
    sgn0_d  = A[WIDTH-1] ^ B[WIDTH-1];
    mul_d   = PW'(mag_a_q) * PW'(mag_b_q);
  end

  // A zero magnitude product negates to zero, so no negative zero can appear.
  always_comb begin
    p_d = sgn_q[MULT_STAGES-1] ? -prod_q[MULT_STAGES-1] : prod_q[MULT_STAGES-1];
  end

  // Data path registers: only move on advance, no reset needed.
  always_ff @(posedge CLK) begin
    if (advance) begin
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      sgn0_q    <= sgn0_d;
      prod_q[0] <= mul_d;
      sgn_q[0]  <= sgn0_q;
      for (int i = 1; i < MULT_STAGES; i++) begin
        prod_q[i] <= prod_q[i-1];
        sgn_q[i]  <= sgn_q[i-1];
      end
    end
  end

  // Valid bits and output register: reset clears everything in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld0_q      <= 1'b0;
      for (int i = 0; i < MULT_STAGES; i++) begin
        vld_q[i] <= 1'b0;
      end
      out_valid_q <= 1'b0;
      p_q         <= '0;
    end else if (advance) begin
      vld0_q   <= in_valid;
      vld_q[0] <= vld0_q;
      for (int i = 1; i < MULT_STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      out_valid_q <= vld_q[MULT_STAGES-1];
      p_q         <= p_d;
    end
  end

  assign P         = p_q;
  assign out_valid = out_valid_q;

`ifdef SIGNED_MULT_QOUT_EN
  logic [PW:0]      rnd_c;
  logic [PW:0]      rnd_sum;
  logic [PW:0]      rnd_shr;
  logic [WIDTH-1:0] pq_d;
  logic [WIDTH-1:0] pq_q;

  // Round half toward +inf, arithmetic shift, then clamp when the upper bits are not a pure sign extension.
  always_comb begin
    rnd_c            = '0;
    rnd_c[FRAC-1]    = 1'b1;
    rnd_sum          = {p_d[PW-1], p_d} + rnd_c;
    rnd_shr          = $signed(rnd_sum) >>> FRAC;
    pq_d             = rnd_shr[WIDTH-1:0];
    if (!(&rnd_shr[PW:WIDTH-1]) && (|rnd_shr[PW:WIDTH-1])) begin
      pq_d = rnd_shr[PW] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pq_q <= '0;
    end else if (advance) begin
      pq_q <= pq_d;
    end
  end

  assign P_Q = pq_q;
`endif

endmodule

// File: tb/tb_signed_mult_pipe.sv
// Self-checking bench for signed_mult_pipe: scoreboard queue fed on accept, monitor pops on output transfer.
// Also exercises the P_Q output when SIGNED_MULT_QOUT_EN is defined.
module tb_signed_mult_pipe;

  localparam int WIDTH       = 16;
  localparam int MULT_STAGES = 2;
  localparam int FRAC        = 8;
  localparam int PW          = 2 * WIDTH;
  localparam int LAT         = MULT_STAGES + 2;

  logic              CLK = 1'b0;
  logic              RST;
  logic [WIDTH-1:0]  A, B;
  logic              in_valid, in_ready;
  logic [PW-1:0]     P;
  logic              out_valid, out_ready;
`ifdef SIGNED_MULT_QOUT_EN
  logic [WIDTH-1:0]  P_Q;
`endif

  int n_vec = 0;
  int n_bad = 0;

  logic [PW-1:0]    exp_q[$];
  logic [WIDTH-1:0] expq_q[$];
  logic [PW-1:0]    e_p;
  logic [WIDTH-1:0] e_q;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  signed_mult_pipe #(
    .WIDTH(WIDTH), .MULT_STAGES(MULT_STAGES), .FRAC(FRAC)
  ) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B),
    .in_valid(in_valid), .in_ready(in_ready),
    .P(P), .out_valid(out_valid), .out_ready(out_ready)
`ifdef SIGNED_MULT_QOUT_EN
    , .P_Q(P_Q)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [PW-1:0] ref_prod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint pr;
    pr = longint'($signed(a)) * longint'($signed(b));
    return pr[PW-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] ref_q(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint pr, r, maxv, minv;
    pr   = longint'($signed(a)) * longint'($signed(b));
    r    = (pr + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    maxv = (longint'(1) <<< (WIDTH - 1)) - 1;
    minv = -(longint'(1) <<< (WIDTH - 1));
    if (r > maxv) r = maxv;
    if (r < minv) r = minv;
    return r[WIDTH-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
      expq_q.delete();
    end else begin
      check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_out: P=0x%0h with nothing outstanding (t=%0t)", P, $time);
        end else begin
          e_p = exp_q.pop_front();
          check("P", 64'(P), 64'(e_p));
`ifdef SIGNED_MULT_QOUT_EN
          e_q = expq_q.pop_front();
          check("P_Q", 64'(P_Q), 64'(e_q));
`endif
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_prod(A, B));
        expq_q.push_back(ref_q(A, B));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int   guard = 0;
    logic acc   = 1'b0;
    A = a;
    B = b;
    in_valid = 1'b1;
    do begin
      @(negedge CLK);
      acc = in_ready;
      @(posedge CLK);
      #1;
      guard++;
    end while (!acc && guard < 100);
    in_valid = 1'b0;
    if (!acc) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles");
    end
  endtask

  // Issue one pair into an empty pipeline and count edges until out_valid shows.
  task automatic send_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    send(a, b);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'(LAT));
  endtask

  task automatic drain();
    int g = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge CLK);
      #1;
      g++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    repeat (4) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return {1'b1, {(WIDTH-1){1'b0}}};
      1:       return {1'b0, {(WIDTH-1){1'b1}}};
      2:       return '0;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  logic [WIDTH-1:0] bp_a [20];
  logic [WIDTH-1:0] bp_b [20];

  initial begin
    int   idx;
    int   t;
    logic acc;

    RST       = 1'b1;
    A         = '0;
    B         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_P", 64'(P), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
`ifdef SIGNED_MULT_QOUT_EN
    check("rst_P_Q", 64'(P_Q), 64'(0));
`endif

    // Sign sweep and extremes
    send_lat(WIDTH'(3), WIDTH'(-5));
    send(WIDTH'(-3), WIDTH'(-5));
    send(WIDTH'(0), WIDTH'(-7));
    send(16'h8000, 16'h8000);
    send(16'h8000, 16'h7FFF);
    send(16'h7FFF, 16'h7FFF);
    send(16'hFFFF, 16'h8000);
`ifdef SIGNED_MULT_QOUT_EN
    send(16'h0180, 16'h0280);
    send(16'h7FFF, 16'h7FFF);
    send(16'h8000, 16'h7FFF);
    send(16'h0001, 16'h0080);
    send(16'hFFFF, 16'h0080);
`endif
    drain();

    // Back-to-back stream with output stalled in cycles 5..9
    for (int i = 0; i < 20; i++) begin
      bp_a[i] = rand_op();
      bp_b[i] = rand_op();
    end
    idx = 0;
    t   = 0;
    while (idx < 20 && t < 200) begin
      A         = bp_a[idx];
      B         = bp_b[idx];
      in_valid  = 1'b1;
      out_ready = !(t >= 5 && t <= 9);
      @(negedge CLK);
      acc = in_ready;
      @(posedge CLK);
      #1;
      if (acc) idx++;
      t++;
    end
    check("bp_all_accepted", 64'(idx), 64'(20));
    drain();

    // Reset with three pairs in flight
    send(WIDTH'(7), WIDTH'(9));
    send(WIDTH'(-11), WIDTH'(13));
    send(WIDTH'(100), WIDTH'(-100));
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_P", 64'(P), 64'(0));
    send_lat(WIDTH'(2), WIDTH'(2));
    drain();

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      A         = rand_op();
      B         = rand_op();
      @(posedge CLK);
      #1;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
